// File: rtl/inv_key_expansion128.sv
// Reverse AES-128 key schedule: takes the round-10 key and walks back to the
// round-0 key, one 32-bit word per cycle, sharing a single registered SubWord.
module inv_key_expansion128 #(
   parameter int unsigned SBOX_LAT = 1
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_key,
   output logic [3:0]   out_round,
   output logic         busy
);

   typedef enum logic [2:0] {IDLE, OUT, W3, W2, W1, W0} state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] a, b, c, d;
   logic [3:0]  rnd;
   logic [31:0] sbox_in;
   logic [31:0] sbox_pipe [SBOX_LAT];
   logic [31:0] sbox_out;
   logic [7:0]  rcon;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = x;
      for (int unsigned i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box: multiplicative inverse as x^254 (maps 0 to 0), then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   // d is final from W2 onwards, so the S-box input stays constant through W0
   assign sbox_in  = {d[23:0], d[31:24]};
   assign sbox_out = sbox_pipe[SBOX_LAT-1];

   // Round constant for the step from round rnd to rnd-1
   always_comb begin
      rcon = 8'h00;
      case (rnd)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // Registered SubWord; result is consumed in W0 (fits latencies of 1 or 2)
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < SBOX_LAT; i++) sbox_pipe[i] <= '0;
      end else begin
         sbox_pipe[0] <= sub_word(sbox_in);
         for (int unsigned i = 1; i < SBOX_LAT; i++) sbox_pipe[i] <= sbox_pipe[i-1];
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nx = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = (rnd == 4'd0) ? IDLE : W3;
         end
         W3:      state_nx = W2;
         W2:      state_nx = W1;
         W1:      state_nx = W0;
         W0:      state_nx = OUT;
         default: state_nx = IDLE;
      endcase
   end

   // Key words updated d, c, b, a so each reads the still-old lower word
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a   <= '0;
         b   <= '0;
         c   <= '0;
         d   <= '0;
         rnd <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               {a, b, c, d} <= in_key;
               rnd          <= 4'd10;
            end
            W3: d <= d ^ c;
            W2: c <= c ^ b;
            W1: b <= b ^ a;
            W0: begin
               a   <= a ^ sbox_out ^ {rcon, 24'h000000};
               rnd <= rnd - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign out_key   = {a, b, c, d};
   assign out_round = rnd;

endmodule

// File: doc/inv_key_expansion128.md
Name: inv_key_expansion128

Overview:
Reverse-direction AES-128 key scheduler for the decryption datapath. It accepts the final (round-10) round key and regenerates the round keys on the fly in decryption order: round 10, then 9, down to 0. It sits between the key loader and the inverse-cipher round unit. It uses one 32-bit SubBytes lookup and processes one word per cycle.

Parameters:
SBOX_LAT, 1, cycles from S-box input to registered S-box result (the SubBytes instance is registered)

Ports:
clock       input   1    system clock, all state on rising edge
resetn      input   1    asynchronous active-low reset
in_valid    input   1    in_key valid
in_ready    output  1    block can accept a new key (high only in IDLE)
in_key      input   128  round-10 key; [127:96]=w40, [95:64]=w41, [63:32]=w42, [31:0]=w43
out_valid   output  1    out_key/out_round valid
out_ready   input   1    consumer accepts current round key
out_key     output  128  round key for out_round; same word packing as in_key
out_round   output  4    round index of out_key, 10 down to 0
busy        output  1    high in every state except IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE; out_valid=0, out_key=0, out_round=0, busy=0, in_ready=1 after release.
- Key register K={a,b,c,d} holds the current round key r. Counter rnd holds r (4 bits).
- Recurrence for r -> r-1:
  - d' = d ^ c
  - c' = c ^ b
  - b' = b ^ a
  - a' = a ^ SubWord(RotWord(d')) ^ Rcon[r]
  - RotWord(x) = {x[23:0], x[31:24]}. Rcon is XORed into byte [31:24] only.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- FSM states: IDLE, OUT, W3, W2, W1, W0.
  - IDLE: in_ready=1. On in_valid: K<=in_key, rnd<=10, go to OUT. Latency is 1 cycle from acceptance to out_valid.
  - OUT: out_valid=1; out_key=K; out_round=rnd. K and rnd are held stable while out_ready=0.
    - On out_ready with rnd==0: go to IDLE.
    - On out_ready with rnd!=0: go to W3.
  - W3: d<=d^c.
  - W2: c<=c^b. Drive the S-box input with RotWord(d) and hold it constant through W0.
  - W1: b<=b^a. The S-box result is registered and valid from W1.
  - W0: a<=a^sbox_out^{Rcon[rnd],24'h0}; rnd<=rnd-1; go to OUT.
  - Words are updated in the order d, c, b, a, so each update reads the not-yet-overwritten lower-indexed word as required.
- Throughput: 5 cycles per round key with out_ready held high. A full schedule from in_valid to the final acceptance takes 1+11+40 = 52 cycles.
- in_ready=0 whenever state!=IDLE. in_valid while busy is ignored and nothing is queued.
- out_valid=0 in IDLE and in W3..W0. out_key content during W states is don't-care.
- When out_ready is asserted with out_valid=0, it is ignored.
- When rnd==0 is accepted, the block returns to IDLE with no extra cycle. A new in_valid is accepted on the next cycle.
- Reset asserted mid-schedule: immediate return to IDLE, all outputs zeroed, and the partial schedule is discarded.
- rnd never wraps: W states are unreachable with rnd==0.

Test Plan:
- FIPS-197 A.1 vector: load in_key=d014f9a8_c9ee2589_e13f0cc8_b6630ca6 with out_ready=1 -> round 10 equals the input; round 9=ac7766f3_19fadc21_28d12941_575c006e; round 0=2b7e1516_28aed2a6_abf71588_09cf4f3c; all 11 round keys match the forward schedule reversed; out_round sequence is 10..0.
- Back-pressure: hold out_ready=0 for 7 cycles at round 9 -> out_key/out_round stay stable and no state advances; on release, round 8=d014f9a8 reversed-chain value (ead27321_b58dbad2_312bf560_7f8d292f) follows 5 cycles later.
- Busy rejection: pulse in_valid with a different key during round 5 -> in_ready=0, schedule unaffected, round 0 is still the original key.
- Back-to-back: assert in_valid in the cycle after round 0 is accepted -> accepted immediately; round 10 appears 1 cycle later.
- Reset mid-run: drop resetn asynchronously during W2 of round 4 -> out_valid=0, busy=0, out_key=0 with no clock edge; after release in_ready=1 and a fresh load runs the full sequence correctly.
- Random keys (1000): compare against a software forward expansion reversed; also check the 5-cycle spacing between out_valid rising edges under continuous out_ready.
